dram_responder: RTL and testbench

- Memory-side responder for the processor's data-memory interface.
- Accepts one read or write request at a time from the datapath: address, write data, and read/write enables taken from control word bits 13 and 14.
- Returns read data (the processor's dram_in) after a programmable latency, with an ack pulse.
- Sits between the Processor top level and on-chip data storage; replaces the combinational DRAM model with a sequential, handshaked responder.

---
 rtl/dram_responder_pkg.sv | 20 ++
 rtl/dram_responder_if.sv | 29 ++
 rtl/dram_array.sv | 23 ++
 rtl/dram_responder.sv | 118 +++++++++++
 tb/tb_dram_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, control-word bit positions
// and default bus widths.
package dram_responder_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 16;

    // Bit positions of the memory controls inside the processor control word.
    localparam int unsigned MEM_WRITE_BIT  = 14;
    localparam int unsigned DATA_READ_BIT  = 13;
    localparam int unsigned INSTR_READ_BIT = 12;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRdWait   = 2'd1,
        StWrCommit = 2'd2,
        StDone     = 2'd3
    } state_e;

endpackage

// File: rtl/dram_responder_if.sv
// Request/response bundle between the processor datapath (master) and the data-memory
// responder (slave).
interface dram_responder_if
    import dram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output addr, wdata, rd_en, wr_en,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  addr, wdata, rd_en, wr_en,
        output rdata, ack, busy, err
    );

endinterface

// File: rtl/dram_array.sv
// Single-port storage, DEPTH x DATA_W, synchronous write and synchronous read, no reset.
module dram_array #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dram_responder.sv
// Sequential, handshaked data-memory responder: one request in flight, programmable read
// latency, range checking and conflict detection in front of dram_array.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic             clock,
    input logic             reset_n,
    dram_responder_if.slave bus
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    assign in_range = 32'(addr_q) < DEPTH;
    assign arr_we   = (state_q == StWrCommit) && in_range;
    // Present the incoming address while idle so the array output is ready even at latency 1.
    assign arr_addr = (state_q == StIdle) ? bus.addr[AW-1:0] : addr_q[AW-1:0];

    dram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (bus.rd_en && bus.wr_en) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (bus.wr_en) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = StWrCommit;
                end else if (bus.rd_en) begin
                    addr_d  = bus.addr;
                    cnt_d   = LAT_LOAD;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = in_range ? arr_rdata : '0;
                    err_d   = !in_range;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrCommit: begin
                err_d   = !in_range;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.rdata = rdata_q;
        bus.ack   = (state_q == StDone);
        bus.err   = (state_q == StDone) && err_q;
        bus.busy  = (state_q == StRdWait) || (state_q == StWrCommit);
    end

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: three instances (read latency 2, 1, 4) driven through
// a shared request path and checked against an array-based reference model.
module tb_dram_responder;
    import dram_responder_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    int          sel = 0;
    logic [15:0] t_ctrl = '0;
    logic [15:0] t_addr = '0;
    logic [15:0] t_wdata = '0;

    dram_responder_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
    dram_responder_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
    dram_responder_if #(.ADDR_W(16), .DATA_W(16)) b2 ();

    assign b0.addr  = t_addr;
    assign b1.addr  = t_addr;
    assign b2.addr  = t_addr;
    assign b0.wdata = t_wdata;
    assign b1.wdata = t_wdata;
    assign b2.wdata = t_wdata;
    assign b0.rd_en = t_ctrl[DATA_READ_BIT] && (sel == 0);
    assign b1.rd_en = t_ctrl[DATA_READ_BIT] && (sel == 1);
    assign b2.rd_en = t_ctrl[DATA_READ_BIT] && (sel == 2);
    assign b0.wr_en = t_ctrl[MEM_WRITE_BIT] && (sel == 0);
    assign b1.wr_en = t_ctrl[MEM_WRITE_BIT] && (sel == 1);
    assign b2.wr_en = t_ctrl[MEM_WRITE_BIT] && (sel == 2);

    dram_responder #(.DEPTH(256), .READ_LATENCY(2)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .bus(b0.slave));
    dram_responder #(.DEPTH(256), .READ_LATENCY(1)) u_lat1 (
        .clock(clock), .reset_n(reset_n), .bus(b1.slave));
    dram_responder #(.DEPTH(256), .READ_LATENCY(4)) u_lat4 (
        .clock(clock), .reset_n(reset_n), .bus(b2.slave));

    logic        o_ack, o_busy, o_err;
    logic [15:0] o_rdata;
    always_comb begin
        o_ack = b0.ack; o_busy = b0.busy; o_err = b0.err; o_rdata = b0.rdata;
        if (sel == 1) begin
            o_ack = b1.ack; o_busy = b1.busy; o_err = b1.err; o_rdata = b1.rdata;
        end else if (sel == 2) begin
            o_ack = b2.ack; o_busy = b2.busy; o_err = b2.err; o_rdata = b2.rdata;
        end
    end

    // Reference model: per-instance word store plus the last returned read value.
    int          lat_of [3] = '{2, 1, 4};
    logic [15:0] ref_mem   [3][256];
    bit          ref_valid [3][256];
    logic [15:0] ref_rdata [3];

    task automatic model_step(input int s, input bit rd, input bit wr, input logic [15:0] a,
                              input logic [15:0] d, output int e_lat,
                              output logic [15:0] e_rdata, output bit e_err);
        bit oor;
        oor = (a >= 16'd256);
        if (rd && wr) begin
            e_lat = 1;
            e_err = 1'b1;
        end else if (wr) begin
            e_lat = 2;
            e_err = oor;
            if (!oor) begin
                ref_mem[s][a[7:0]]   = d;
                ref_valid[s][a[7:0]] = 1'b1;
            end
        end else begin
            e_lat = lat_of[s] + 1;
            e_err = oor;
            ref_rdata[s] = oor ? 16'h0000 : ref_mem[s][a[7:0]];
        end
        e_rdata = ref_rdata[s];
    endtask

    // Issue one request; lat counts edges from the acceptance edge (1) to the first ack cycle.
    task automatic do_req(input int s, input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input bit poke, output int lat,
                          output logic [15:0] rdv, output bit erv, output bit busy_ok);
        int n;
        @(negedge clock);
        sel     = s;
        t_addr  = a;
        t_wdata = d;
        t_ctrl  = '0;
        t_ctrl[DATA_READ_BIT] = rd;
        t_ctrl[MEM_WRITE_BIT] = wr;
        @(negedge clock);
        n = 1; lat = 0; rdv = '0; erv = 1'b0; busy_ok = 1'b1;
        t_ctrl = '0;
        if (poke) begin
            // A competing write to the same word while busy must be ignored.
            t_ctrl[MEM_WRITE_BIT] = 1'b1;
            t_wdata = 16'h2222;
        end
        while (lat == 0 && n < 40) begin
            if (o_ack) begin
                lat = n; rdv = o_rdata; erv = o_err;
                if (o_busy) busy_ok = 1'b0;
            end else begin
                if (!o_busy) busy_ok = 1'b0;
                @(negedge clock);
                n++;
            end
        end
        t_ctrl = '0;
        checks++;
        if (lat == 0) begin
            fails++;
            $display("FAIL req_timeout: inst=%0d addr=%h got no ack within %0d edges", s, a, n);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({o_ack, o_busy, o_err} !== 3'b000) begin
                fails++;
                $display("FAIL reset_flags inst=%0d: got %b want 000", s, {o_ack, o_busy, o_err});
            end
            checks++;
            if (o_rdata !== 16'h0000) begin
                fails++;
                $display("FAIL reset_rdata inst=%0d: got %h want 0000", s, o_rdata);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        sel = 0;
        #1;
        checks++;
        if ({o_ack, o_busy, o_err} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want 000", {o_ack, o_busy, o_err});
        end
        for (int s = 0; s < 3; s++) ref_rdata[s] = 16'h0000;
    endtask

    task automatic test_write_read;
        int lat, el; logic [15:0] rv, er; bit ev, ee, bo;
        model_step(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, el, er, ee);
        do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 2 || ev !== 1'b0 || !bo) begin
            fails++;
            $display("FAIL write_ack: lat=%0d err=%b busy_ok=%b want lat=2 err=0 busy_ok=1",
                     lat, ev, bo);
        end
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 3 || rv !== 16'hBEEF || ev !== 1'b0 || !bo) begin
            fails++;
            $display("FAIL read_after_write: lat=%0d rdata=%h err=%b want lat=3 rdata=beef err=0",
                     lat, rv, ev);
        end
    endtask

    task automatic test_latency_sweep;
        int lat, el; logic [15:0] rv, er; bit ev, ee, bo;
        for (int s = 1; s < 3; s++) begin
            model_step(s, 1'b0, 1'b1, 16'h0020, 16'h1234, el, er, ee);
            do_req(s, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, lat, rv, ev, bo);
            model_step(s, 1'b1, 1'b0, 16'h0020, 16'h0000, el, er, ee);
            do_req(s, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, rv, ev, bo);
            checks++;
            if (lat !== (s == 1 ? 2 : 5) || rv !== 16'h1234 || !bo) begin
                fails++;
                $display("FAIL latency_sweep inst=%0d: lat=%0d rdata=%h busy_ok=%b want lat=%0d",
                         s, lat, rv, bo, (s == 1 ? 2 : 5));
            end
        end
    endtask

    task automatic test_out_of_range;
        int lat, el; logic [15:0] rv, er; bit ev, ee, bo;
        model_step(0, 1'b0, 1'b1, 16'h0000, 16'h5555, el, er, ee);
        do_req(0, 1'b0, 1'b1, 16'h0000, 16'h5555, 1'b0, lat, rv, ev, bo);
        model_step(0, 1'b0, 1'b1, 16'h0100, 16'hAAAA, el, er, ee);
        do_req(0, 1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 2 || ev !== 1'b1) begin
            fails++;
            $display("FAIL oor_write: lat=%0d err=%b want lat=2 err=1", lat, ev);
        end
        model_step(0, 1'b1, 1'b0, 16'h0100, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 3 || ev !== 1'b1 || rv !== 16'h0000) begin
            fails++;
            $display("FAIL oor_read: lat=%0d err=%b rdata=%h want lat=3 err=1 rdata=0000",
                     lat, ev, rv);
        end
        model_step(0, 1'b1, 1'b0, 16'h0000, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (rv !== 16'h5555 || ev !== 1'b0) begin
            fails++;
            $display("FAIL oor_no_alias: mem[0]=%h err=%b want 5555 err=0", rv, ev);
        end
    endtask

    task automatic test_conflict;
        int lat, el; logic [15:0] rv, er; bit ev, ee, bo;
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rv, ev, bo);
        model_step(0, 1'b1, 1'b1, 16'h0010, 16'h1111, el, er, ee);
        do_req(0, 1'b1, 1'b1, 16'h0010, 16'h1111, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 1 || ev !== 1'b1 || rv !== 16'hBEEF) begin
            fails++;
            $display("FAIL conflict: lat=%0d err=%b rdata=%h want lat=1 err=1 rdata=beef",
                     lat, ev, rv);
        end
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (rv !== 16'hBEEF) begin
            fails++;
            $display("FAIL conflict_no_write: rdata=%h want beef", rv);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, el, extra; logic [15:0] rv, er; bit ev, ee, bo;
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, lat, rv, ev, bo);
        checks++;
        if (lat !== 3 || rv !== 16'hBEEF || !bo) begin
            fails++;
            $display("FAIL busy_first: lat=%0d rdata=%h busy_ok=%b want lat=3 rdata=beef",
                     lat, rv, bo);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clock);
            if (o_ack || o_busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_second_ignored: %0d active cycles after ack, want 0", extra);
        end
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (rv !== 16'hBEEF) begin
            fails++;
            $display("FAIL busy_no_write: rdata=%h want beef", rv);
        end
    endtask

    task automatic test_reset_mid_read;
        int lat, el, acks; logic [15:0] rv, er; bit ev, ee, bo;
        model_step(0, 1'b0, 1'b1, 16'h0005, 16'h0777, el, er, ee);
        do_req(0, 1'b0, 1'b1, 16'h0005, 16'h0777, 1'b0, lat, rv, ev, bo);
        model_step(0, 1'b1, 1'b0, 16'h0010, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rv, ev, bo);
        @(negedge clock);
        sel = 0; t_addr = 16'h0005; t_ctrl = '0; t_ctrl[DATA_READ_BIT] = 1'b1;
        @(negedge clock);
        t_ctrl = '0;
        checks++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_read_busy: busy=%b want 1", o_busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_rdata !== 16'h0000 || o_ack !== 1'b0) begin
            fails++;
            $display("FAIL mid_read_reset: busy=%b rdata=%h ack=%b want 0 0000 0",
                     o_busy, o_rdata, o_ack);
        end
        acks = 0;
        repeat (2) begin
            @(negedge clock);
            if (o_ack) acks++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (o_ack || o_busy) acks++;
        end
        checks++;
        if (acks !== 0) begin
            fails++;
            $display("FAIL abandoned_read: %0d ack/busy cycles, want 0", acks);
        end
        for (int s = 0; s < 3; s++) ref_rdata[s] = 16'h0000;
        model_step(0, 1'b1, 1'b0, 16'h0005, 16'h0000, el, er, ee);
        do_req(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, lat, rv, ev, bo);
        checks++;
        if (lat !== 3 || rv !== 16'h0777) begin
            fails++;
            $display("FAIL after_reset_read: lat=%0d rdata=%h want lat=3 rdata=0777", lat, rv);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 90; i++) begin
            int s, op, lat, el;
            bit rd, wr, ev, ee, bo;
            logic [15:0] a, d, rv, er;
            s  = $urandom_range(2, 0);
            op = $urandom_range(9, 0);
            a  = ($urandom_range(7, 0) == 0) ? 16'($urandom_range(65535, 256))
                                              : 16'($urandom_range(31, 0));
            d  = 16'($urandom);
            rd = (op == 0) || (op > 4);
            wr = (op <= 4);
            if (rd && !wr && a < 16'd256 && !ref_valid[s][a[7:0]]) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            model_step(s, rd, wr, a, d, el, er, ee);
            do_req(s, rd, wr, a, d, 1'b0, lat, rv, ev, bo);
            checks++;
            if (lat !== el || ev !== ee || rv !== er || !bo) begin
                fails++;
                $display("FAIL random[%0d] inst=%0d rd=%b wr=%b addr=%h: lat=%0d err=%b rdata=%h busy_ok=%b want lat=%0d err=%b rdata=%h",
                         i, s, rd, wr, a, lat, ev, rv, bo, el, ee, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency_sweep();
        test_out_of_range();
        test_conflict();
        test_busy_ignore();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
